// File: rtl/i2c_pkg.sv
// Shared I2C definitions: protocol state encoding, R/W and ACK bit values,
// and the 7-bit address compare used by target and controller.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        WRITE    = 3'd3,
        WR_ACK   = 3'd4,
        READ     = 3'd5,
        RD_ACK   = 3'd6,
        IGNORE   = 3'd7
    } i2c_state_e;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;

    // General call (8'h00) never matches a legal target address, so no special case.
    function automatic logic i2c_addr_match(input logic [7:0] addr_byte, input logic [6:0] target);
        return (addr_byte[7:1] == target);
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes the asynchronous SCL/SDA pads and derives SCL edges and
// START/STOP conditions one flop after the synchronizer.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   w_scl;
    logic                   w_sda;

    // Synchronizer chains plus edge-detect history; reset to the idle (high) bus level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign w_scl     = r_scl_sync[SYNC_STAGES-1];
    assign w_sda     = r_sda_sync[SYNC_STAGES-1];
    assign sda_s     = w_sda;
    assign scl_rise  = w_scl & ~r_scl_prev;
    assign scl_fall  = ~w_scl & r_scl_prev;
    assign start_det = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign stop_det  = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: 7-bit address match, byte-wide write/read exchange with
// local logic, no clock stretching. All outputs are registered.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       addr_hit,
    output logic       rw,
    output logic       busy
);

    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic       w_sda;
    logic [7:0] w_shift_in;

    i2c_state_e r_state;
    logic [7:0] r_shift;
    logic [3:0] r_bitcnt;
    logic       r_ack_phase;
    logic       r_tx_cap;
    logic       r_sda_oe;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_tx_req;
    logic       r_addr_hit;
    logic       r_rw;
    logic       r_busy;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start),
        .stop_det  (w_stop),
        .sda_s     (w_sda)
    );

    assign w_shift_in = {r_shift[6:0], w_sda};

    // Protocol FSM; START/STOP take priority over every state and any SCL edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_shift     <= 8'h00;
            r_bitcnt    <= 4'd0;
            r_ack_phase <= 1'b0;
            r_tx_cap    <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_tx_req    <= 1'b0;
            r_addr_hit  <= 1'b0;
            r_rw        <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_addr_hit <= 1'b0;
            if (r_tx_cap) begin
                r_shift  <= tx_data;
                r_tx_cap <= 1'b0;
            end
            if (w_stop) begin
                r_state  <= IDLE;
                r_busy   <= 1'b0;
                r_sda_oe <= 1'b0;
            end else if (w_start) begin
                r_state  <= ADDR;
                r_bitcnt <= 4'd7;
                r_busy   <= 1'b1;
                r_sda_oe <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: r_sda_oe <= 1'b0;
                    ADDR: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_shift_in;
                            r_bitcnt <= r_bitcnt - 4'd1;
                            if (r_bitcnt == 4'd0) begin
                                if (i2c_addr_match(w_shift_in, TARGET_ADDR)) begin
                                    r_addr_hit  <= 1'b1;
                                    r_rw        <= w_sda;
                                    r_ack_phase <= 1'b0;
                                    r_state     <= ADDR_ACK;
                                end else begin
                                    r_state <= IGNORE;
                                end
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_phase) begin
                                r_sda_oe    <= 1'b1;
                                r_ack_phase <= 1'b1;
                            end else if (r_rw == I2C_RW_READ) begin
                                // ACK release and first read bit share this fall
                                r_sda_oe <= ~r_shift[7];
                                r_shift  <= {r_shift[6:0], 1'b0};
                                r_bitcnt <= 4'd7;
                                r_state  <= READ;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_bitcnt <= 4'd7;
                                r_state  <= WRITE;
                            end
                        end else if (w_scl_rise && r_ack_phase && (r_rw == I2C_RW_READ)) begin
                            r_tx_req <= 1'b1;
                            r_tx_cap <= 1'b1;
                        end
                    end
                    WRITE: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_shift_in;
                            r_bitcnt <= r_bitcnt - 4'd1;
                            if (r_bitcnt == 4'd0) begin
                                r_rx_data   <= w_shift_in;
                                r_rx_valid  <= 1'b1;
                                r_ack_phase <= 1'b0;
                                r_state     <= WR_ACK;
                            end
                        end
                    end
                    WR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_phase) begin
                                r_sda_oe    <= 1'b1;
                                r_ack_phase <= 1'b1;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_bitcnt <= 4'd7;
                                r_state  <= WRITE;
                            end
                        end
                    end
                    READ: begin
                        if (w_scl_fall) begin
                            if (r_bitcnt == 4'd0) begin
                                r_sda_oe <= 1'b0;
                                r_state  <= RD_ACK;
                            end else begin
                                r_sda_oe <= ~r_shift[7];
                                r_shift  <= {r_shift[6:0], 1'b0};
                                r_bitcnt <= r_bitcnt - 4'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (w_scl_rise) begin
                            if (w_sda == I2C_ACK) begin
                                r_tx_req <= 1'b1;
                                r_tx_cap <= 1'b1;
                                r_bitcnt <= 4'd8;
                                r_state  <= READ;
                            end else begin
                                r_state <= IGNORE;
                            end
                        end
                    end
                    IGNORE: r_sda_oe <= 1'b0;
                    default: begin
                        r_state  <= IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe   = r_sda_oe;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_req   = r_tx_req;
    assign addr_hit = r_addr_hit;
    assign rw       = r_rw;
    assign busy     = r_busy;

endmodule
